hash_burst_sched: RTL
=====================

# hash_burst_sched

Sequencer for weight-stream hash verification in the secure wrapper. It passively monitors the weights AXI read-data channel and splits the stream into bursts on `rlast`. Each burst is forwarded through a small FIFO to a streaming hash engine, and the returned digest is compared against an expected-digest table loaded over the AXI-Lite register port. Results are reported as sticky `hash_verified` / `hash_error` status with the failing burst index.

## Interface
Parameters:
- AXI_WIDTH, 128, monitored read-data width
- AXIL_WIDTH, 32, register data width
- AXIL_ADDR_WIDTH, 40, register address width
- DIGEST_BITS, 64, digest width; must be a multiple of AXIL_WIDTH
- N_ENTRIES, 8, expected-digest table depth, power of 2, max 16
- FIFO_DEPTH, 4, beat buffer depth, power of 2

Ports. Single clock `clk`; reset `rstn` is synchronous, active-low.
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- reg_wr_addr  in  AXIL_ADDR_WIDTH  register write byte address
- reg_wr_data  in  AXIL_WIDTH  write data
- reg_wr_en  in  1  write strobe, one cycle
- reg_wr_ack  out  1  write acknowledge pulse
- mon_rvalid, mon_rready  in  1 each  monitored weights R handshake
- mon_rdata  in  AXI_WIDTH  monitored beat data
- mon_rlast  in  1  last beat of burst
- eng_start  out  1  one-cycle pulse, engine state reinit
- eng_valid  out  1  beat valid to engine
- eng_data  out  AXI_WIDTH  beat to engine
- eng_last  out  1  last beat of burst
- eng_ready  in  1  engine accepts beat
- eng_done  in  1  digest valid, one cycle
- eng_digest  in  DIGEST_BITS  computed digest
- hash_verified  out  1  all configured bursts matched, sticky
- hash_error  out  1  failure, sticky
- err_code  out  2  1 = mismatch, 2 = FIFO overflow, 3 = beat while awaiting digest
- err_idx  out  4  burst index at failure
- busy  out  1  state is ARMED, STREAM or WAIT_DIGEST

## Operation
Register map. Decode uses `reg_wr_addr[7:0]`, word aligned; unmapped writes are acked and ignored.
- 0x00 CTRL.
  - bit0 enable: writing 1 in IDLE arms the block; ignored in other states.
  - bit1 clear: self-clearing; forces IDLE, zeroes status, burst_idx and FIFO. Table contents are kept.
- 0x04 NUM_BURSTS[4:0]. Values above N_ENTRIES clamp to N_ENTRIES.
- 0x40 + 8·i + 4·w: expected digest entry i, word w (w=0 is the LSW). Writable in any state.

FSM states: IDLE, ARMED, STREAM, WAIT_DIGEST, DONE, FAIL.
- IDLE → ARMED on enable, with burst_idx=0. If NUM_BURSTS=0, go IDLE → DONE instead.
- ARMED: `eng_start` is high during the first cycle only. Accepted beats are pushed to the FIFO. The first push moves to STREAM, or directly to WAIT_DIGEST if that beat carries rlast.
- STREAM: a push with `mon_rlast` → WAIT_DIGEST.
- WAIT_DIGEST: the FIFO drains.
  - `eng_done` and `eng_digest` == table[burst_idx]: increment burst_idx. If it equals NUM_BURSTS → DONE, else → ARMED.
  - Mismatch → FAIL, err_code=1.
  - Any accepted monitor beat here → FAIL, err_code=3.
- Push while FIFO full with no pop in the same cycle → FAIL, err_code=2. Push and pop in the same cycle on a full FIFO is legal.
- DONE and FAIL hold until clear or reset.
- FIFO pops to the engine on `eng_valid && eng_ready`. Each entry stores {last, data}.
- Monitoring is passive: the block never drives `mon_rready`.

## Timing
- Reset values: every output is 0, the FIFO is empty, state is IDLE, the table is all zeros, NUM_BURSTS=0.
- `reg_wr_ack`: registered, high one cycle after `reg_wr_en`. Register effects are visible in the cycle after the ack.
- Transition to ARMED is registered; `eng_start` is high in the first ARMED cycle.
- FIFO path: `eng_valid` is driven from not-empty. A beat pushed in cycle t can appear on `eng_valid` at t+1 at the earliest.
- `eng_done` in cycle t: compare at t, so state, `hash_verified`, `hash_error`, `err_*` and `busy` all update at t+1.
- Simultaneous events:
  - clear and `eng_done` in the same cycle: clear wins.
  - reset has priority over everything.
  - reset mid-burst returns to reset values; any partially buffered beats are dropped.
- `eng_done` outside WAIT_DIGEST is ignored.

## Test plan
- Single burst: NUM_BURSTS=1, entry0=0x1122334455667788, 4-beat burst, engine returns the matching digest. Expect:
  - one `eng_start` pulse and 4 `eng_valid` beats, `eng_last` on the 4th;
  - `hash_verified`=1 one cycle after `eng_done`, `busy`=0.
- Mismatch on second of three bursts: engine returns entry1 XOR 1. Expect:
  - `hash_error`=1, err_code=1, err_idx=1;
  - no third `eng_start`.
- Backpressure: FIFO_DEPTH=4, `eng_ready`=0, 5 beats accepted. Expect FAIL with err_code=2 on the 5th push. Repeat with a pop in the same cycle as the 5th push: no error.
- Beat arriving in WAIT_DIGEST before `eng_done` → err_code=3, err_idx=0.
- Corner cases:
  - NUM_BURSTS=0 with enable → `hash_verified`=1 with no `eng_start`;
  - NUM_BURSTS=20 clamps to 8.
- Clear issued in the same cycle as `eng_done` → IDLE with all status 0. Reset asserted mid-burst → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/hash_burst_sched.sv
// rtl/hash_burst_sched.sv - weight-stream burst sequencer feeding a hash engine and checking digests
// Splits the monitored R channel on rlast, buffers beats to the engine, compares digests to a table.
module hash_burst_sched #(
  parameter int AXI_WIDTH       = 128,
  parameter int AXIL_WIDTH      = 32,
  parameter int AXIL_ADDR_WIDTH = 40,
  parameter int DIGEST_BITS     = 64,
  parameter int N_ENTRIES       = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [AXIL_ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [AXIL_WIDTH-1:0]      reg_wr_data,
  input  logic                       reg_wr_en,
  output logic                       reg_wr_ack,
  input  logic                       mon_rvalid,
  input  logic                       mon_rready,
  input  logic [AXI_WIDTH-1:0]       mon_rdata,
  input  logic                       mon_rlast,
  output logic                       eng_start,
  output logic                       eng_valid,
  output logic [AXI_WIDTH-1:0]       eng_data,
  output logic                       eng_last,
  input  logic                       eng_ready,
  input  logic                       eng_done,
  input  logic [DIGEST_BITS-1:0]     eng_digest,
  output logic                       hash_verified,
  output logic                       hash_error,
  output logic [1:0]                 err_code,
  output logic [3:0]                 err_idx,
  output logic                       busy
);

  localparam int WORDS  = DIGEST_BITS / AXIL_WIDTH;
  localparam int WBYTES = AXIL_WIDTH / 8;
  localparam int EBYTES = WORDS * WBYTES;
  localparam int IDXW   = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int WW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic [2:0]             state;
  logic                   wr_q;
  logic [7:0]             wr_addr_q;
  logic [AXIL_WIDTH-1:0]  wr_data_q;
  logic [4:0]             num_bursts;
  logic [4:0]             burst_idx;
  logic [DIGEST_BITS-1:0] tbl [N_ENTRIES];

  logic [AXI_WIDTH:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [PW:0]            count;

  logic ctrl_wr, num_wr, do_clear, do_enable, tbl_wr;
  logic [IDXW-1:0] tbl_idx;
  logic [WW-1:0]   tbl_w;
  logic mon_fire, push, pop, full, empty, overflow, fifo_wr;

  logic unused_addr;
  assign unused_addr = &{1'b0, reg_wr_addr[AXIL_ADDR_WIDTH-1:8]};

  // Writes are staged one cycle so the ack precedes the register effect.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_q      <= reg_wr_en;
      wr_addr_q <= reg_wr_addr[7:0];
      wr_data_q <= reg_wr_data;
    end
  end

  assign reg_wr_ack = wr_q;
  assign ctrl_wr    = wr_q && (wr_addr_q == 8'h00);
  assign num_wr     = wr_q && (wr_addr_q == 8'h04);
  assign do_clear   = ctrl_wr && wr_data_q[1];
  assign do_enable  = ctrl_wr && wr_data_q[0];

  always_comb begin
    int off;
    off     = int'(wr_addr_q) - 64;
    tbl_wr  = wr_q && (off >= 0) && (off < N_ENTRIES * EBYTES);
    tbl_idx = IDXW'(off / EBYTES);
    tbl_w   = WW'((off % EBYTES) / WBYTES);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      num_bursts <= '0;
      for (int i = 0; i < N_ENTRIES; i++) tbl[i] <= '0;
    end else begin
      if (num_wr)
        num_bursts <= (wr_data_q[4:0] > 5'(N_ENTRIES)) ? 5'(N_ENTRIES) : wr_data_q[4:0];
      if (tbl_wr)
        tbl[tbl_idx][int'(tbl_w)*AXIL_WIDTH +: AXIL_WIDTH] <= wr_data_q;
    end
  end

  assign mon_fire = mon_rvalid && mon_rready;
  assign push     = mon_fire && ((state == S_ARMED) || (state == S_STREAM));
  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign pop      = !empty && eng_ready;
  assign overflow = push && full && !pop;
  assign fifo_wr  = push && !overflow;

  assign eng_valid = !empty;
  assign {eng_last, eng_data} = empty ? '0 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= {mon_rlast, mon_rdata};
  end

  always_ff @(posedge clk) begin
    if (!rstn || do_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= S_IDLE;
      burst_idx     <= '0;
      hash_verified <= 1'b0;
      hash_error    <= 1'b0;
      err_code      <= 2'd0;
      err_idx       <= 4'd0;
      eng_start     <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      if (do_clear) begin
        state         <= S_IDLE;
        burst_idx     <= '0;
        hash_verified <= 1'b0;
        hash_error    <= 1'b0;
        err_code      <= 2'd0;
        err_idx       <= 4'd0;
      end else begin
        case (state)
          S_IDLE: if (do_enable) begin
            burst_idx <= '0;
            if (num_bursts == 5'd0) begin
              state         <= S_DONE;
              hash_verified <= 1'b1;
            end else begin
              state     <= S_ARMED;
              eng_start <= 1'b1;
            end
          end
          S_ARMED, S_STREAM: begin
            if (overflow) begin
              state      <= S_FAIL;
              hash_error <= 1'b1;
              err_code   <= 2'd2;
              err_idx    <= burst_idx[3:0];
            end else if (push) begin
              state <= mon_rlast ? S_WAIT : S_STREAM;
            end
          end
          S_WAIT: begin
            // A new beat before the digest means the burst framing is broken.
            if (mon_fire) begin
              state      <= S_FAIL;
              hash_error <= 1'b1;
              err_code   <= 2'd3;
              err_idx    <= burst_idx[3:0];
            end else if (eng_done) begin
              if (eng_digest == tbl[burst_idx[IDXW-1:0]]) begin
                burst_idx <= burst_idx + 5'd1;
                if (burst_idx + 5'd1 == num_bursts) begin
                  state         <= S_DONE;
                  hash_verified <= 1'b1;
                end else begin
                  state     <= S_ARMED;
                  eng_start <= 1'b1;
                end
              end else begin
                state      <= S_FAIL;
                hash_error <= 1'b1;
                err_code   <= 2'd1;
                err_idx    <= burst_idx[3:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == S_ARMED) || (state == S_STREAM) || (state == S_WAIT);

endmodule
